// File: rtl/pattern_pkg.sv
// Shared definitions for the video test-pattern generator: mode encodings,
// colour-bar lookup and channel MSB alignment.
package pattern_pkg;

    typedef enum logic [1:0] {
        MODE_XY    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_t;

    localparam int MAX_C_W = 12;

    // {R,G,B} on/off flags for bars left to right: white, yellow, cyan, green,
    // magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] flags;
        flags = 3'b000;
        case (idx)
            3'd0: flags = 3'b111;
            3'd1: flags = 3'b110;
            3'd2: flags = 3'b011;
            3'd3: flags = 3'b010;
            3'd4: flags = 3'b101;
            3'd5: flags = 3'b100;
            3'd6: flags = 3'b001;
            default: flags = 3'b000;
        endcase
        return flags;
    endfunction

    // Left-justifies an 8-bit value in the widest channel; callers shift down to C_W.
    function automatic logic [MAX_C_W-1:0] msb_align(input logic [7:0] v);
        return {v, {(MAX_C_W-8){1'b0}}};
    endfunction

endpackage

// File: rtl/pattern_gen_if.sv
// Raster-in / RGB-out bundle between the timing generator, the pattern
// generator and the TMDS encoders.
interface pattern_gen_if #(
    parameter int X_W  = 11,
    parameter int Y_W  = 10,
    parameter int C_W  = 8,
    parameter int FC_W = 8
);
    logic            pix_en;
    logic [X_W-1:0]  counterX;
    logic [Y_W-1:0]  counterY;
    logic            de_in;
    logic            hsync_in;
    logic            vsync_in;
    logic [1:0]      mode_sel;
    logic [C_W-1:0]  red;
    logic [C_W-1:0]  green;
    logic [C_W-1:0]  blue;
    logic            de_out;
    logic            hsync_out;
    logic            vsync_out;
    logic [FC_W-1:0] frame_cnt;

    modport master (
        output pix_en, counterX, counterY, de_in, hsync_in, vsync_in, mode_sel,
        input  red, green, blue, de_out, hsync_out, vsync_out, frame_cnt
    );

    modport slave (
        input  pix_en, counterX, counterY, de_in, hsync_in, vsync_in, mode_sel,
        output red, green, blue, de_out, hsync_out, vsync_out, frame_cnt
    );
endinterface

// File: rtl/pg_bar_index.sv
// Maps a horizontal position to one of eight colour-bar indices, registered as
// part of the first pipeline stage.
module pg_bar_index #(
    parameter int X_W      = 11,
    parameter int H_ACTIVE = 1280
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [X_W-1:0] x,
    output logic [2:0]     idx
);

    logic [6:0] ge;

    // Thermometer code against fixed boundaries; past the last one is black.
    for (genvar k = 1; k < 8; k++) begin : g_cmp
        localparam int BOUND = (k * H_ACTIVE) / 8;
        assign ge[k-1] = (x >= X_W'(BOUND));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 3'd0;
        end else if (en) begin
            idx <= 3'($countones(ge));
        end
    end

endmodule

// File: rtl/pattern_gen.sv
// Two-stage registered video test-pattern generator with frame-aligned mode
// switching and delay-matched timing strobes.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int          X_W       = 11,
    parameter int          Y_W       = 10,
    parameter int          C_W       = 8,
    parameter int          H_ACTIVE  = 1280,
    parameter int          SQ_LOG2   = 5,
    parameter int          FC_W      = 8,
    parameter logic [23:0] SOLID_RGB = 24'h808080
) (
    input  logic         clk,
    input  logic         rst,
    pattern_gen_if.slave bus
);

    localparam int SHIFT = MAX_C_W - C_W;
    localparam logic [C_W-1:0] SOLID_R = C_W'(msb_align(SOLID_RGB[23:16]) >> SHIFT);
    localparam logic [C_W-1:0] SOLID_G = C_W'(msb_align(SOLID_RGB[15:8]) >> SHIFT);
    localparam logic [C_W-1:0] SOLID_B = C_W'(msb_align(SOLID_RGB[7:0]) >> SHIFT);

    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [X_W-1:0]  x_sum;
    logic            vsync_d;
    logic            armed;
    logic            frame_start;
    logic [FC_W-1:0] frame_q;
    mode_t           mode_q;

    logic            de_s1, hs_s1, vs_s1, chk_s1;
    logic [7:0]      xy_r_s1, xy_g_s1, xy_b_s1;
    logic [2:0]      bar_s1;

    logic [C_W-1:0]  r_nxt, g_nxt, b_nxt;
    logic [C_W-1:0]  r_q, g_q, b_q;
    logic            de_q, hs_q, vs_q;
    logic [2:0]      bar_flags;
    logic            unused_y;

    assign x        = bus.counterX;
    assign y        = bus.counterY;
    assign unused_y = ^y;
    assign x_sum    = x + X_W'(frame_q);

    // armed stays low until vsync has been seen low, so a vsync held high
    // through reset release is not mistaken for a new frame.
    assign frame_start = bus.pix_en & bus.vsync_in & ~vsync_d & armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
            armed   <= 1'b0;
            frame_q <= '0;
            mode_q  <= MODE_XY;
        end else if (bus.pix_en) begin
            vsync_d <= bus.vsync_in;
            if (!bus.vsync_in) begin
                armed <= 1'b1;
            end
            if (frame_start) begin
                frame_q <= frame_q + FC_W'(1);
                mode_q  <= mode_t'(bus.mode_sel);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_s1   <= 1'b0;
            hs_s1   <= 1'b0;
            vs_s1   <= 1'b0;
            chk_s1  <= 1'b0;
            xy_r_s1 <= 8'd0;
            xy_g_s1 <= 8'd0;
            xy_b_s1 <= 8'd0;
        end else if (bus.pix_en) begin
            de_s1   <= bus.de_in;
            hs_s1   <= bus.hsync_in;
            vs_s1   <= bus.vsync_in;
            chk_s1  <= x_sum[SQ_LOG2] ^ y[SQ_LOG2];
            xy_r_s1 <= {x[5:0] & {6{y[4:3] == ~x[4:3]}}, 2'b00};
            xy_g_s1 <= x[7:0] & {8{y[6]}};
            xy_b_s1 <= y[7:0];
        end
    end

    pg_bar_index #(
        .X_W      (X_W),
        .H_ACTIVE (H_ACTIVE)
    ) u_bar_index (
        .clk (clk),
        .rst (rst),
        .en  (bus.pix_en),
        .x   (x),
        .idx (bar_s1)
    );

    assign bar_flags = bar_rgb(bar_s1);

    // The mode applied here is the latched mode, so a pattern change takes
    // effect together with the frame counter step.
    always_comb begin
        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        case (mode_q)
            MODE_XY: begin
                r_nxt = C_W'(msb_align(xy_r_s1) >> SHIFT);
                g_nxt = C_W'(msb_align(xy_g_s1) >> SHIFT);
                b_nxt = C_W'(msb_align(xy_b_s1) >> SHIFT);
            end
            MODE_BARS: begin
                r_nxt = {C_W{bar_flags[2]}};
                g_nxt = {C_W{bar_flags[1]}};
                b_nxt = {C_W{bar_flags[0]}};
            end
            MODE_CHECK: begin
                r_nxt = {C_W{chk_s1}};
                g_nxt = {C_W{chk_s1}};
                b_nxt = {C_W{chk_s1}};
            end
            MODE_SOLID: begin
                r_nxt = SOLID_R;
                g_nxt = SOLID_G;
                b_nxt = SOLID_B;
            end
            default: begin
                r_nxt = '0;
                g_nxt = '0;
                b_nxt = '0;
            end
        endcase
        if (!de_s1) begin
            r_nxt = '0;
            g_nxt = '0;
            b_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            de_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else if (bus.pix_en) begin
            r_q  <= r_nxt;
            g_q  <= g_nxt;
            b_q  <= b_nxt;
            de_q <= de_s1;
            hs_q <= hs_s1;
            vs_q <= vs_s1;
        end
    end

    assign bus.red       = r_q;
    assign bus.green     = g_q;
    assign bus.blue      = b_q;
    assign bus.de_out    = de_q;
    assign bus.hsync_out = hs_q;
    assign bus.vsync_out = vs_q;
    assign bus.frame_cnt = frame_q;

endmodule
